wb_arbiter: RTL and testbench

- Writeback stage directly upstream of the 32-entry register array.
- Merges results from the execute (ALU) path and the load path into the single write bus G and the per-register write-enable vector R_in.
- Load wins on conflict; a one-entry skid buffer holds the losing ALU result.
- Also exports a pending-write mask and a retired-write counter.

---
 rtl/riskproc_pkg.sv | 24 ++
 rtl/wb_arbiter_rd_decoder.sv | 19 +
 rtl/wb_arbiter.sv | 104 ++++++++++
 tb/tb_wb_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riskproc_pkg.sv
// Shared writeback constants, result bundle and destination decode helper.
// Imported by the writeback arbiter and its decoder.
`timescale 1ns/1ps
package riskproc_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    // x0 is hardwired, so its enable bit is never raised
    function automatic logic [NREGS-1:0] onehot_rd(input logic [REG_AW-1:0] rd);
        logic [NREGS-1:0] v;
        v     = '0;
        v[rd] = 1'b1;
        v[0]  = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/wb_arbiter_rd_decoder.sv
// Register index to one-hot write enable, gated by en.
// Index 0 never produces an enable.
`timescale 1ns/1ps
module rd_decoder
    import riskproc_pkg::*;
(
    input  logic              en,
    input  logic [REG_AW-1:0] rd,
    output logic [NREGS-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot = onehot_rd(rd);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and load results onto the register write bus.
// Loads always win; a single skid entry holds a displaced ALU result.
`timescale 1ns/1ps
module wb_arbiter
    import riskproc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              ld_valid,
    input  logic [REG_AW-1:0] ld_rd,
    input  logic [XLEN-1:0]   ld_data,
    output logic [XLEN-1:0]   G,
    output logic [NREGS-1:0]  R_in,
    output logic [NREGS-1:0]  pend_mask,
    output logic [31:0]       wb_count
);

    logic             buf_full;
    wb_entry_t        buf_q;
    wb_entry_t        alu_e;
    wb_entry_t        ld_e;
    wb_entry_t        wr_sel;
    logic             wr_en;
    logic             alu_fire;
    logic [NREGS-1:0] wr_onehot;

    // Ready depends only on buffer state, never on ld_valid
    assign alu_ready = !buf_full;
    assign alu_fire  = alu_valid && alu_ready;

    assign alu_e = '{rd: alu_rd, data: alu_data};
    assign ld_e  = '{rd: ld_rd,  data: ld_data};

    always_comb begin
        wr_en  = 1'b0;
        wr_sel = '0;
        priority case (1'b1)
            ld_valid: begin
                wr_en  = 1'b1;
                wr_sel = ld_e;
            end
            buf_full: begin
                wr_en  = 1'b1;
                wr_sel = buf_q;
            end
            alu_fire: begin
                wr_en  = 1'b1;
                wr_sel = alu_e;
            end
            default: begin
                wr_en  = 1'b0;
                wr_sel = '0;
            end
        endcase
    end

    rd_decoder u_wr_dec (
        .en     (wr_en),
        .rd     (wr_sel.rd),
        .onehot (wr_onehot)
    );

    rd_decoder u_pend_dec (
        .en     (buf_full),
        .rd     (buf_q.rd),
        .onehot (pend_mask)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            G        <= '0;
            R_in     <= '0;
            wb_count <= '0;
        end else begin
            R_in <= wr_onehot;
            if (wr_en) begin
                G <= wr_sel.data;
            end
            if (|wr_onehot) begin
                wb_count <= wb_count + 32'd1;
            end
        end
    end

    // Skid entry: filled only when a load displaces an accepted ALU beat
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_full <= 1'b0;
            buf_q    <= '0;
        end else if (ld_valid) begin
            if (alu_fire) begin
                buf_full <= 1'b1;
                buf_q    <= alu_e;
            end
        end else if (buf_full) begin
            buf_full <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for the writeback arbiter.
// Each task resets, drives a scenario and checks hand-computed outputs.
`timescale 1ns/1ps
module tb_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [31:0] G;
    logic [31:0] R_in;
    logic [31:0] pend_mask;
    logic [31:0] wb_count;

    int n_vec;
    int n_err;

    wb_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .G         (G),
        .R_in      (R_in),
        .pend_mask (pend_mask),
        .wb_count  (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        ld_valid  = 1'b0;
        ld_rd     = '0;
        ld_data   = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] d);
        alu_valid = 1'b1;
        alu_rd    = rd;
        alu_data  = d;
    endtask

    task automatic drive_ld(input logic [4:0] rd, input logic [31:0] d);
        ld_valid = 1'b1;
        ld_rd    = rd;
        ld_data  = d;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (G !== 32'h0) begin
            n_err++;
            $display("FAIL reset_G: got %h want %h", G, 32'h0);
        end
        n_vec++;
        if (R_in !== 32'h0) begin
            n_err++;
            $display("FAIL reset_R_in: got %h want %h", R_in, 32'h0);
        end
        n_vec++;
        if (pend_mask !== 32'h0) begin
            n_err++;
            $display("FAIL reset_pend: got %h want %h", pend_mask, 32'h0);
        end
        n_vec++;
        if (wb_count !== 32'h0) begin
            n_err++;
            $display("FAIL reset_cnt: got %0d want %0d", wb_count, 0);
        end
        n_vec++;
        if (alu_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b want %b", alu_ready, 1'b1);
        end
    endtask

    task automatic test_alu_alone();
        do_reset();
        drive_alu(5'd5, 32'hDEADBEEF);
        tick();
        idle();
        n_vec++;
        if (R_in !== 32'h0000_0020) begin
            n_err++;
            $display("FAIL alu_R_in: got %h want %h", R_in, 32'h20);
        end
        n_vec++;
        if (G !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL alu_G: got %h want %h", G, 32'hDEADBEEF);
        end
        tick();
        n_vec++;
        if (R_in !== 32'h0) begin
            n_err++;
            $display("FAIL alu_R_in_clr: got %h want %h", R_in, 32'h0);
        end
        n_vec++;
        if (G !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL alu_G_hold: got %h want %h", G, 32'hDEADBEEF);
        end
        n_vec++;
        if (wb_count !== 32'd1) begin
            n_err++;
            $display("FAIL alu_cnt: got %0d want %0d", wb_count, 1);
        end
    endtask

    task automatic test_collision();
        do_reset();
        drive_ld(5'd3, 32'h11);
        drive_alu(5'd7, 32'h22);
        n_vec++;
        if (alu_ready !== 1'b1) begin
            n_err++;
            $display("FAIL col_ready0: got %b want %b", alu_ready, 1'b1);
        end
        tick();
        idle();
        n_vec++;
        if (R_in !== 32'h8 || G !== 32'h11) begin
            n_err++;
            $display("FAIL col_c1: got R_in=%h G=%h want R_in=%h G=%h",
                     R_in, G, 32'h8, 32'h11);
        end
        n_vec++;
        if (alu_ready !== 1'b0 || pend_mask !== 32'h80) begin
            n_err++;
            $display("FAIL col_c1_buf: got ready=%b pend=%h want ready=0 pend=%h",
                     alu_ready, pend_mask, 32'h80);
        end
        tick();
        n_vec++;
        if (R_in !== 32'h80 || G !== 32'h22) begin
            n_err++;
            $display("FAIL col_c2: got R_in=%h G=%h want R_in=%h G=%h",
                     R_in, G, 32'h80, 32'h22);
        end
        n_vec++;
        if (alu_ready !== 1'b1 || pend_mask !== 32'h0) begin
            n_err++;
            $display("FAIL col_c2_buf: got ready=%b pend=%h want ready=1 pend=0",
                     alu_ready, pend_mask);
        end
        n_vec++;
        if (wb_count !== 32'd2) begin
            n_err++;
            $display("FAIL col_cnt: got %0d want %0d", wb_count, 2);
        end
    endtask

    task automatic test_x0_write();
        do_reset();
        drive_alu(5'd0, 32'h55);
        n_vec++;
        if (alu_ready !== 1'b1) begin
            n_err++;
            $display("FAIL x0_ready: got %b want %b", alu_ready, 1'b1);
        end
        tick();
        idle();
        n_vec++;
        if (R_in !== 32'h0 || G !== 32'h55) begin
            n_err++;
            $display("FAIL x0_c1: got R_in=%h G=%h want R_in=0 G=%h",
                     R_in, G, 32'h55);
        end
        n_vec++;
        if (wb_count !== 32'd0 || pend_mask !== 32'h0) begin
            n_err++;
            $display("FAIL x0_state: got cnt=%0d pend=%h want cnt=0 pend=0",
                     wb_count, pend_mask);
        end
        tick();
        n_vec++;
        if (R_in !== 32'h0 || alu_ready !== 1'b1) begin
            n_err++;
            $display("FAIL x0_c2: got R_in=%h ready=%b want R_in=0 ready=1",
                     R_in, alu_ready);
        end
    endtask

    task automatic test_starvation();
        logic [31:0] exp_r;
        do_reset();
        drive_ld(5'd3, 32'h11);
        drive_alu(5'd7, 32'h22);
        tick();
        // ALU keeps offering rd=9 while stalled; accepted once the buffer drains
        drive_alu(5'd9, 32'h99);
        for (int i = 1; i <= 3; i++) begin
            n_vec++;
            if (alu_ready !== 1'b0) begin
                n_err++;
                $display("FAIL starve_ready_c%0d: got %b want 0", i, alu_ready);
            end
            drive_ld(5'(i), 32'hA0 + 32'(i));
            tick();
            exp_r = 32'h1 << i;
            n_vec++;
            if (R_in !== exp_r || G !== 32'hA0 + 32'(i)) begin
                n_err++;
                $display("FAIL starve_c%0d: got R_in=%h G=%h want R_in=%h G=%h",
                         i + 1, R_in, G, exp_r, 32'hA0 + 32'(i));
            end
        end
        ld_valid = 1'b0;
        n_vec++;
        if (alu_ready !== 1'b0 || pend_mask !== 32'h80) begin
            n_err++;
            $display("FAIL starve_c4: got ready=%b pend=%h want ready=0 pend=%h",
                     alu_ready, pend_mask, 32'h80);
        end
        tick();
        n_vec++;
        if (R_in !== 32'h80 || G !== 32'h22) begin
            n_err++;
            $display("FAIL starve_c5: got R_in=%h G=%h want R_in=%h G=%h",
                     R_in, G, 32'h80, 32'h22);
        end
        n_vec++;
        if (alu_ready !== 1'b1) begin
            n_err++;
            $display("FAIL starve_c5_ready: got %b want 1", alu_ready);
        end
        tick();
        idle();
        n_vec++;
        if (R_in !== 32'h200 || G !== 32'h99) begin
            n_err++;
            $display("FAIL starve_c6: got R_in=%h G=%h want R_in=%h G=%h",
                     R_in, G, 32'h200, 32'h99);
        end
        n_vec++;
        if (wb_count !== 32'd6) begin
            n_err++;
            $display("FAIL starve_cnt: got %0d want %0d", wb_count, 6);
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        drive_ld(5'd3, 32'h11);
        drive_alu(5'd7, 32'h22);
        tick();
        idle();
        n_vec++;
        if (pend_mask !== 32'h80) begin
            n_err++;
            $display("FAIL rmid_pend: got %h want %h", pend_mask, 32'h80);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++;
        if (R_in !== 32'h0 || G !== 32'h0 || pend_mask !== 32'h0) begin
            n_err++;
            $display("FAIL rmid_out: got R_in=%h G=%h pend=%h want all 0",
                     R_in, G, pend_mask);
        end
        n_vec++;
        if (alu_ready !== 1'b1 || wb_count !== 32'd0) begin
            n_err++;
            $display("FAIL rmid_state: got ready=%b cnt=%0d want ready=1 cnt=0",
                     alu_ready, wb_count);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (R_in !== 32'h0) begin
                n_err++;
                $display("FAIL rmid_stale_%0d: got R_in=%h want 0", i, R_in);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_r;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive_alu(5'(i), 32'h100 * 32'(i));
            n_vec++;
            if (alu_ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_ready_%0d: got %b want 1", i, alu_ready);
            end
            tick();
            exp_r = 32'h1 << i;
            n_vec++;
            if (R_in !== exp_r || G !== 32'h100 * 32'(i)) begin
                n_err++;
                $display("FAIL b2b_c%0d: got R_in=%h G=%h want R_in=%h G=%h",
                         i, R_in, G, exp_r, 32'h100 * 32'(i));
            end
        end
        idle();
        n_vec++;
        if (wb_count !== 32'd4) begin
            n_err++;
            $display("FAIL b2b_cnt: got %0d want %0d", wb_count, 4);
        end
        tick();
        n_vec++;
        if (R_in !== 32'h0 || G !== 32'h400) begin
            n_err++;
            $display("FAIL b2b_idle: got R_in=%h G=%h want R_in=0 G=%h",
                     R_in, G, 32'h400);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        idle();
        test_reset();
        test_alu_alone();
        test_collision();
        test_x0_write();
        test_starvation();
        test_reset_mid_op();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
